cnt_load_ctrl: RTL and testbench

CNT_LOAD_CTRL -- requirements
Module: cnt_load_ctrl

---
 rtl/cnt_ctrl_pkg.sv | 13 +
 rtl/cnt_load_ctrl.sv | 95 +++++++++
 tb/tb_cnt_load_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the cascaded-counter load controller.
package cnt_ctrl_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StFin
  } state_e;

endpackage

// File: rtl/cnt_load_ctrl.sv
// Load/enable controller for two cascaded 4-bit counters; runs REPS terminal-count periods.
// Optional macro CNT_LOAD_CTRL_AUTO_RELOAD_EN: FIN returns to LOAD and runs repeat until abort.
import cnt_ctrl_pkg::*;

module cnt_load_ctrl #(
  parameter int unsigned REPS_W = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic              ABORT,
  input  logic [CNT_W-1:0]  PRESET,
  input  logic [REPS_W-1:0] REPS,
  input  logic              RCO_IN,
  output logic              LD_L,
  output logic              ENP,
  output logic              ENT,
  output logic [3:0]        D_LO,
  output logic [3:0]        D_HI,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [REPS_W-1:0] RepOne = 1;

  state_e             state_q;
  logic [REPS_W-1:0]  rep_cnt_q;
  logic [REPS_W-1:0]  reps_q;
  logic [CNT_W-1:0]   preset_q;
  logic               last_rep;
  logic               reload;

  // reps_q is never 0 while running, so this compare cannot underflow in RUN.
  assign last_rep = (rep_cnt_q == (reps_q - RepOne));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= StIdle;
      rep_cnt_q <= '0;
      reps_q    <= '0;
      preset_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START) begin
            preset_q <= PRESET;
            reps_q   <= (REPS == '0) ? RepOne : REPS;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          if (ABORT) begin
            state_q <= StIdle;
          end else begin
            rep_cnt_q <= '0;
            state_q   <= StRun;
          end
        end
        StRun: begin
          if (ABORT) begin
            state_q <= StIdle;
          end else if (RCO_IN) begin
            if (last_rep) begin
              state_q <= StFin;
            end else begin
              rep_cnt_q <= rep_cnt_q + RepOne;
            end
          end
        end
        StFin: begin
`ifdef CNT_LOAD_CTRL_AUTO_RELOAD_EN
          state_q <= StLoad;
`else
          state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Mid-run reload must hit the counters on the same edge that follows RCO.
  always_comb begin
    reload = (state_q == StRun) && RCO_IN && !ABORT && !last_rep;
    LD_L   = !((state_q == StLoad) || reload);
    ENP    = (state_q == StRun);
    ENT    = (state_q == StRun);
    BUSY   = (state_q == StLoad) || (state_q == StRun);
    DONE   = (state_q == StFin);
  end

  assign D_LO = preset_q[3:0];
  assign D_HI = preset_q[7:4];

endmodule

// File: tb/tb_cnt_load_ctrl.sv
// Bench for cnt_load_ctrl: behavioural 8-bit counter pair plus an expected-trace scoreboard.
module tb_cnt_load_ctrl;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [7:0] PRESET = 8'h00;
  logic [3:0] REPS = 4'h0;
  logic       RCO_IN;
  logic       LD_L, ENP, ENT, BUSY, DONE;
  logic [3:0] D_LO, D_HI;

  cnt_load_ctrl #(.REPS_W(4)) dut (
    .CLK(CLK), .CLR(CLR), .START(START), .ABORT(ABORT), .PRESET(PRESET), .REPS(REPS),
    .RCO_IN(RCO_IN), .LD_L(LD_L), .ENP(ENP), .ENT(ENT), .D_LO(D_LO), .D_HI(D_HI),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Two cascaded 74163-style counters seen as one 8-bit counter.
  logic [7:0] cnt = 8'h00;
  always @(posedge CLK) begin
    if (!LD_L) cnt <= {D_HI, D_LO};
    else if (ENP && ENT) cnt <= cnt + 8'h01;
  end
  assign RCO_IN = (cnt == 8'hFF) && ENT;

  typedef struct packed {
    logic ld_l;
    logic enp;
    logic ent;
    logic busy;
    logic done;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] m_preset = 8'h00;
  int nvec = 0;
  int nfail = 0;
  int run_cyc = 0;
  int done_n = 0;
  int ld_low_n = 0;
  int rco_n = 0;
  int done_at[4];
  int rco_at[4];

  task automatic check(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(logic ld_l, logic en, logic busy, logic done);
    exp_t e;
    e.ld_l = ld_l;
    e.enp  = en;
    e.ent  = en;
    e.busy = busy;
    e.done = done;
    return e;
  endfunction

  // Whole-run expected waveform from preset and repetition count.
  function automatic void push_runs(logic [7:0] p, int r, int nruns);
    int eff = (r == 0) ? 1 : r;
    int per = 256 - int'(p);
    for (int n = 0; n < nruns; n++) begin
      expq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
      for (int rr = 0; rr < eff; rr++)
        for (int c = 0; c < per; c++)
          expq.push_back(mk(!((c == per - 1) && (rr < eff - 1)), 1'b1, 1'b1, 1'b0));
      expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
    end
    m_preset = p;
    run_cyc  = 0;
    done_n   = 0;
    ld_low_n = 0;
    rco_n    = 0;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    exp_t a;
    e = mk(1'b1, 1'b0, 1'b0, 1'b0);
    if (expq.size() != 0) e = expq.pop_front();
    a = {LD_L, ENP, ENT, BUSY, DONE};
    check("ctl{ld_l,enp,ent,busy,done}", int'(a), int'(e));
    check("d_hi_lo", int'({D_HI, D_LO}), int'(m_preset));
    run_cyc++;
    if (DONE && done_n < 4) begin done_at[done_n] = run_cyc; done_n++; end
    if (RCO_IN && rco_n < 4) begin rco_at[rco_n] = run_cyc; rco_n++; end
    if (!LD_L) ld_low_n++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [7:0] p, input logic [3:0] r, input int nruns);
    PRESET = p;
    REPS   = r;
    START  = 1'b1;
    tick();
    START  = 1'b0;
    PRESET = ~p;
    REPS   = 4'hF;
    push_runs(p, int'(r), nruns);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (expq.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (expq.size() != 0) begin
      check("run_timeout", 1, 0);
      expq.delete();
    end
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ld_l"}, int'(LD_L), 1);
    check({tag, "_enp_ent"}, int'({ENP, ENT}), 0);
    check({tag, "_busy_done"}, int'({BUSY, DONE}), 0);
    check({tag, "_d"}, int'({D_HI, D_LO}), 0);
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    repeat (2) tick();
    CLR = 1'b0;
    repeat (2) tick();

`ifndef CNT_LOAD_CTRL_AUTO_RELOAD_EN
    // One 6-cycle period.
    start(8'hFA, 4'd1, 1);
    wait_idle(50);
    check("fa_rco_at", rco_at[0], 7);
    check("fa_done_at", done_at[0], 8);
    check("fa_done_n", done_n, 1);
    check("fa_ld_low_n", ld_low_n, 1);

    // Three 16-cycle periods; a mid-run START with new values must be ignored.
    start(8'hF0, 4'd3, 1);
    repeat (20) tick();
    PRESET = 8'h12;
    REPS   = 4'd1;
    START  = 1'b1;
    tick();
    START  = 1'b0;
    wait_idle(200);
    check("f0_done_n", done_n, 1);
    check("f0_done_at", done_at[0], 50);
    check("f0_ld_low_n", ld_low_n, 3);
    check("f0_rco_n", rco_n, 3);
    check("f0_rco0_at", rco_at[0], 17);
    check("f0_period1", rco_at[1] - rco_at[0], 16);
    check("f0_period2", rco_at[2] - rco_at[1], 16);

    // REPS=0 acts as 1; PRESET=FF gives a one-cycle period.
    start(8'hFF, 4'd0, 1);
    wait_idle(20);
    check("ff_rco_at", rco_at[0], 2);
    check("ff_done_at", done_at[0], 3);
    check("ff_done_n", done_n, 1);
`else
    // Auto-reload: DONE every 2*4+2 cycles until ABORT.
    begin
      int k = 0;
      start(8'hFC, 4'd2, 3);
      while (done_n < 2 && k < 100) begin
        tick();
        k++;
      end
      check("auto_done_n", done_n, 2);
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      expq.delete();
      repeat (3) tick();
      check("auto_done0_at", done_at[0], 10);
      check("auto_done_spacing", done_at[1] - done_at[0], 10);
      check("auto_done_n_after_abort", done_n, 2);
    end
`endif

    // ABORT coincident with the final RCO, with a stray START in RUN.
    begin
      int k = 0;
      start(8'hFE, 4'd1, 1);
      while (!RCO_IN && k < 20) begin
        tick();
        k++;
      end
      check("abort_rco_seen", int'(RCO_IN), 1);
      ABORT  = 1'b1;
      START  = 1'b1;
      PRESET = 8'h33;
      tick();
      ABORT = 1'b0;
      START = 1'b0;
      expq.delete();
      repeat (4) tick();
      check("abort_done_n", done_n, 0);
    end

    // Asynchronous CLR mid-run.
    start(8'hF8, 4'd2, 1);
    repeat (5) tick();
    #2;
    CLR = 1'b1;
    expq.delete();
    m_preset = 8'h00;
    #1;
    check_reset_outputs("clr_mid_run");
    tick();
    CLR = 1'b0;
    repeat (3) tick();
    check("clr_done_n", done_n, 0);

`ifndef CNT_LOAD_CTRL_AUTO_RELOAD_EN
    // Normal operation after CLR.
    start(8'hFD, 4'd1, 1);
    wait_idle(20);
    check("post_clr_done_at", done_at[0], 5);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
